// File: rtl/noc_pkg.sv
// Shared flit-level definitions for the super-hub NoC blocks.
// Flit type lives in the top two bits of every flit.
package noc_pkg;

    localparam int FLIT_W       = 20;
    localparam int NUM_CLUSTERS = 4;

    localparam logic [1:0] FT_SINGLE = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_BODY   = 2'b10;
    localparam logic [1:0] FT_TAIL   = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sh_flit_fifo.sv
// Per-cluster flit FIFO: push/pop with first-word-fall-through read data.
// Latency: a flit pushed at edge N is visible on data_out after edge N.
// Backpressure: push while full drops the flit and pulses overflow, unless a pop frees the slot.
module sh_flit_fifo #(
    parameter int FLIT_W     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] data_in,
    output logic [FLIT_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign data_out = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/sh_up_arbiter.sv
// Super-hub uplink scheduler: four credit-backed cluster FIFOs, round-robin with wormhole lock.
// Latency: 2 cycles from up_valid to out_valid; 1 flit/cycle sustained.
// Backpressure: sends only while downstream credit > 0; upstream credit returned on up_co per pop.
module sh_up_arbiter #(
    parameter int FLIT_W      = 20,
    parameter int FIFO_DEPTH  = 4,
    parameter int OUT_CREDITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*FLIT_W-1:0] up_data,
    input  logic [3:0]          up_valid,
    output logic [3:0]          up_co,
    output logic [FLIT_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ci,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic [3:0]          err
);

    import noc_pkg::*;

    localparam int CW = $clog2(OUT_CREDITS + 1);

    logic [FLIT_W-1:0] head [NUM_CLUSTERS];
    logic [3:0]        empty;
    logic [3:0]        full;
    logic [3:0]        ovf;
    logic [3:0]        pop;
    logic [3:0]        req;
    logic [3:0]        orphan;

    arb_state_t        state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        grant_d;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic [1:0]        sel;
    logic              found;
    logic              send;
    logic              has_credit;
    logic [1:0]        sel_type;
    logic [CW-1:0]     credit_q;

    for (genvar g = 0; g < NUM_CLUSTERS; g++) begin : g_fifo
        sh_flit_fifo #(
            .FLIT_W     (FLIT_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (up_valid[g]),
            .pop      (pop[g]),
            .data_in  (up_data[g*FLIT_W +: FLIT_W]),
            .data_out (head[g]),
            .empty    (empty[g]),
            .full     (full[g]),
            .overflow (ovf[g])
        );
    end

    assign has_credit = (credit_q != '0);
    assign busy       = (state_q == ST_LOCKED);
    assign sel_type   = head[sel][FLIT_W-1 -: 2];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_id;
        pop     = '0;
        req     = '0;
        orphan  = '0;
        send    = 1'b0;
        found   = 1'b0;
        win     = '0;
        idx     = '0;
        sel     = grant_id;

        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < NUM_CLUSTERS; i++) begin
                    if (!empty[i]) begin
                        if (head[i][FLIT_W-1] == 1'b1) orphan[i] = 1'b1;
                        else                           req[i]    = 1'b1;
                    end
                end
                for (int k = 0; k < NUM_CLUSTERS; k++) begin
                    idx = rr_q + 2'(k);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                // Orphans drain regardless of credit; they never reach the output.
                pop = orphan;
                if (found && has_credit) begin
                    send     = 1'b1;
                    sel      = win;
                    grant_d  = win;
                    pop[win] = 1'b1;
                    if (head[win][FLIT_W-1 -: 2] == FT_HEAD) state_d = ST_LOCKED;
                    else                                     rr_d    = win + 2'd1;
                end
            end
            ST_LOCKED: begin
                if (!empty[grant_id] && has_credit) begin
                    send          = 1'b1;
                    pop[grant_id] = 1'b1;
                    if (sel_type == FT_TAIL) begin
                        state_d = ST_IDLE;
                        rr_d    = grant_id + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            grant_id  <= '0;
            credit_q  <= CW'(OUT_CREDITS);
            out_valid <= 1'b0;
            out_data  <= '0;
            up_co     <= '0;
            err       <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_id  <= grant_d;
            out_valid <= send;
            up_co     <= pop;
            err       <= err | ovf | orphan;
            if (send) out_data <= head[sel];
            if (send && !out_ci) begin
                credit_q <= credit_q - 1'b1;
            end else if (out_ci && !send && (credit_q < CW'(OUT_CREDITS))) begin
                credit_q <= credit_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sh_up_arbiter.sv
// Scoreboard bench for sh_up_arbiter: expected flits queued at stimulus time, checked as they leave.
module tb_sh_up_arbiter;

    import noc_pkg::*;

    localparam int FW = 20;

    typedef struct packed {
        logic [1:0]    id;
        logic [FW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*FW-1:0] up_data = '0;
    logic [3:0]    up_valid = '0;
    logic [3:0]    up_co;
    logic [FW-1:0] out_data;
    logic          out_valid;
    logic          out_ci;
    logic [1:0]    grant_id;
    logic          busy;
    logic [3:0]    err;

    logic          auto_en = 1'b0;
    logic          auto_p  = 1'b0;
    logic          man_ci  = 1'b0;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    int   co_cnt[4];
    int   srv_cnt[4];

    assign out_ci = auto_p | man_ci;

    always #5 clk = ~clk;

    sh_up_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_co     (up_co),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ci    (out_ci),
        .grant_id  (grant_id),
        .busy      (busy),
        .err       (err)
    );

    task automatic exp_add(input int i, input logic [FW-1:0] d);
        exp_t e;
        e.id   = 2'(i);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_flit(input int i, input logic [FW-1:0] d);
        up_valid[i]           = 1'b1;
        up_data[i*FW +: FW]   = d;
    endtask

    task automatic clear_in();
        up_valid = '0;
    endtask

    // One clock: inputs are captured at posedge, outputs sampled at the following negedge.
    task automatic tick();
        exp_t e;
        logic exp_busy;
        @(posedge clk);
        @(negedge clk);
        auto_p = 1'b0;
        for (int i = 0; i < 4; i++) if (up_co[i]) co_cnt[i]++;
        if (out_valid) begin
            n_out++;
            srv_cnt[grant_id]++;
            auto_p = auto_en;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got id=%0d data=%05h, required no output", grant_id, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, out_data} !== {e.id, e.data}) begin
                    fails++;
                    $display("FAIL scoreboard: got id=%0d data=%05h, required id=%0d data=%05h",
                             grant_id, out_data, e.id, e.data);
                end
                exp_busy = (e.data[FW-1 -: 2] == FT_HEAD) || (e.data[FW-1 -: 2] == FT_BODY);
                tests++;
                if (busy !== exp_busy) begin
                    fails++;
                    $display("FAIL busy_flag: got %b, required %b (data=%05h)", busy, exp_busy, e.data);
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d flits outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        auto_p   = 1'b0;
        man_ci   = 1'b0;
        up_valid = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        tests += 6;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (out_data !== '0)    begin fails++; $display("FAIL rst_out_data: got %05h, required 00000", out_data); end
        if (up_co !== 4'b0)     begin fails++; $display("FAIL rst_up_co: got %b, required 0000", up_co); end
        if (grant_id !== 2'd0)  begin fails++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (err !== 4'b0)       begin fails++; $display("FAIL rst_err: got %b, required 0000", err); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        int co0;
        do_reset();
        auto_en = 1'b1;
        co0 = co_cnt[2];
        exp_add(2, 20'h01234);
        push_flit(2, 20'h01234);
        tick();
        clear_in();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early: got out_valid=%b one cycle after push, required 0", out_valid); end
        tick();
        tests += 3;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL single_latency: got out_valid=%b, required 1", out_valid); end
        if (grant_id !== 2'd2)  begin fails++; $display("FAIL single_grant: got %0d, required 2", grant_id); end
        if (up_co !== 4'b0100)  begin fails++; $display("FAIL single_up_co: got %b, required 0100", up_co); end
        run(3);
        tests += 2;
        if (co_cnt[2] - co0 != 1) begin fails++; $display("FAIL single_co_count: got %0d pulses, required 1", co_cnt[2] - co0); end
        if (out_data !== 20'h01234) begin fails++; $display("FAIL single_hold: got %05h, required 01234", out_data); end
    endtask

    task automatic test_wormhole();
        logic [FW-1:0] p0 [3];
        logic [FW-1:0] p1 [3];
        do_reset();
        auto_en = 1'b1;
        p0 = '{20'h4A001, 20'h8A002, 20'hCA003};
        p1 = '{20'h4B001, 20'h8B002, 20'hCB003};
        for (int k = 0; k < 3; k++) exp_add(0, p0[k]);
        for (int k = 0; k < 3; k++) exp_add(1, p1[k]);
        for (int k = 0; k < 3; k++) begin
            push_flit(0, p0[k]);
            push_flit(1, p1[k]);
            tick();
        end
        clear_in();
        wait_drain(20);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL wormhole_release: got busy=%b, required 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [FW-1:0] d;
        do_reset();
        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) srv_cnt[i] = 0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                d = {2'b00, 2'(i), 4'(c), 12'h5A5};
                exp_add(i, d);
                push_flit(i, d);
            end
            tick();
        end
        clear_in();
        wait_drain(40);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (srv_cnt[i] != 4) begin fails++; $display("FAIL rr_served_%0d: got %0d, required 4", i, srv_cnt[i]); end
        end
    endtask

    task automatic test_credit();
        int base;
        do_reset();
        auto_en = 1'b0;
        base = n_out;
        for (int k = 0; k < 6; k++) begin
            exp_add(0, {2'b00, 6'h10, 12'(k)});
            push_flit(0, {2'b00, 6'h10, 12'(k)});
            tick();
        end
        clear_in();
        run(6);
        tests++;
        if (n_out - base != 4) begin fails++; $display("FAIL credit_stall: got %0d sent, required 4", n_out - base); end
        man_ci = 1'b1; tick(); man_ci = 1'b0;
        run(5);
        tests++;
        if (n_out - base != 5) begin fails++; $display("FAIL credit_one_more: got %0d sent, required 5", n_out - base); end
        man_ci = 1'b1; tick(); man_ci = 1'b0;
        run(3);
        // Credit is now 0 and the FIFO empty; six returns must saturate at four.
        man_ci = 1'b1; run(6); man_ci = 1'b0;
        base = n_out;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) exp_add(0, {2'b00, 6'h20, 12'(k)});
            push_flit(0, {2'b00, 6'h20, 12'(k)});
            tick();
        end
        clear_in();
        run(8);
        tests += 2;
        if (n_out - base != 4) begin fails++; $display("FAIL credit_saturate: got %0d sent, required 4", n_out - base); end
        if (exp_q.size() != 0) begin fails++; $display("FAIL credit_pending: got %0d unsent, required 0", exp_q.size()); end
    endtask

    task automatic test_orphan();
        int co0;
        int base;
        do_reset();
        auto_en = 1'b1;
        co0  = co_cnt[3];
        base = n_out;
        push_flit(3, 20'h80303);
        tick();
        clear_in();
        run(4);
        tests += 3;
        if (co_cnt[3] - co0 != 1) begin fails++; $display("FAIL orphan_co: got %0d pulses, required 1", co_cnt[3] - co0); end
        if (err !== 4'b1000)      begin fails++; $display("FAIL orphan_err: got %b, required 1000", err); end
        if (n_out != base)        begin fails++; $display("FAIL orphan_out: got %0d sent, required 0", n_out - base); end
        run(3);
        tests++;
        if (err !== 4'b1000) begin fails++; $display("FAIL orphan_sticky: got %b, required 1000", err); end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] s [5];
        do_reset();
        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) srv_cnt[i] = 0;
        for (int k = 0; k < 5; k++) s[k] = {2'b00, 6'h31, 12'(k)};
        exp_add(0, 20'h40001);
        push_flit(0, 20'h40001);
        for (int k = 0; k < 5; k++) begin
            push_flit(1, s[k]);
            tick();
            up_valid[0] = 1'b0;
        end
        clear_in();
        run(3);
        tests += 2;
        if (err !== 4'b0010) begin fails++; $display("FAIL overflow_err: got %b, required 0010", err); end
        if (busy !== 1'b1)   begin fails++; $display("FAIL overflow_locked: got busy=%b, required 1", busy); end
        exp_add(0, 20'hC0002);
        for (int k = 0; k < 4; k++) exp_add(1, s[k]);
        push_flit(0, 20'hC0002);
        tick();
        clear_in();
        wait_drain(20);
        run(3);
        tests++;
        if (srv_cnt[1] != 4) begin fails++; $display("FAIL overflow_delivered: got %0d, required 4", srv_cnt[1]); end
    endtask

    task automatic test_reset_mid();
        int base;
        int c;
        do_reset();
        auto_en = 1'b0;
        base = n_out;
        exp_add(1, 20'h4C001);
        exp_add(1, 20'h8C002);
        push_flit(1, 20'h4C001); tick();
        push_flit(1, 20'h8C002); tick();
        clear_in();
        c = 0;
        while (n_out - base < 2 && c < 10) begin tick(); c++; end
        tests++;
        if (n_out - base != 2) begin fails++; $display("FAIL mid_sent: got %0d, required 2", n_out - base); end
        #2 rst = 1'b0;
        #1;
        tests += 5;
        if (out_valid !== 1'b0 || out_data !== '0) begin fails++; $display("FAIL mid_rst_out: got v=%b d=%05h, required 0/00000", out_valid, out_data); end
        if (grant_id !== 2'd0) begin fails++; $display("FAIL mid_rst_grant: got %0d, required 0", grant_id); end
        if (busy !== 1'b0)     begin fails++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (up_co !== 4'b0)    begin fails++; $display("FAIL mid_rst_up_co: got %b, required 0000", up_co); end
        if (err !== 4'b0)      begin fails++; $display("FAIL mid_rst_err: got %b, required 0000", err); end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        base = n_out;
        exp_add(2, 20'h4D001);
        exp_add(2, 20'h8D002);
        exp_add(2, 20'hCD003);
        exp_add(2, 20'h0D004);
        push_flit(2, 20'h4D001); tick();
        push_flit(2, 20'h8D002); tick();
        push_flit(2, 20'hCD003); tick();
        push_flit(2, 20'h0D004); tick();
        push_flit(2, 20'h0D005); tick();
        clear_in();
        run(8);
        tests += 2;
        if (n_out - base != 4) begin fails++; $display("FAIL mid_credit_restore: got %0d sent, required 4", n_out - base); end
        if (exp_q.size() != 0) begin fails++; $display("FAIL mid_pending: got %0d unsent, required 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            co_cnt[i]  = 0;
            srv_cnt[i] = 0;
        end
        test_reset();
        test_single();
        test_wormhole();
        test_round_robin();
        test_credit();
        test_orphan();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
